// File: rtl/safe_pkg.sv
// -----------------------------------------------------------------------------
// safe_pkg
// Shared definitions for the safe dial front end:
//   - default dial size, position width and debounce length
//   - combination digit select encodings and default combination digits
//   - quadrature (Gray) step classification helper
// No ports.
// -----------------------------------------------------------------------------
package safe_pkg;

  localparam int DIAL_MAX_DEF   = 40;
  localparam int CNT_W_DEF      = 6;
  localparam int DEB_CYCLES_DEF = 4;

  localparam logic [1:0] SEL_D0  = 2'd0;
  localparam logic [1:0] SEL_D1  = 2'd1;
  localparam logic [1:0] SEL_D2  = 2'd2;
  localparam logic [1:0] SEL_RSV = 2'd3;

  localparam int COMBO0_DEF = 12;
  localparam int COMBO1_DEF = 30;
  localparam int COMBO2_DEF = 7;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ERR  = 2'd3
  } step_t;

  // Up order is 00 -> 01 -> 11 -> 10 -> 00; AB is {a, b}.
  function automatic step_t gray_step(input logic [1:0] prev, input logic [1:0] nxt);
    logic [1:0] fwd;
    logic [1:0] bwd;
    fwd = 2'b00;
    bwd = 2'b00;
    case (prev)
      2'b00:   begin fwd = 2'b01; bwd = 2'b10; end
      2'b01:   begin fwd = 2'b11; bwd = 2'b00; end
      2'b11:   begin fwd = 2'b10; bwd = 2'b01; end
      default: begin fwd = 2'b00; bwd = 2'b11; end
    endcase
    if (nxt == prev)     return STEP_NONE;
    else if (nxt == fwd) return STEP_UP;
    else if (nxt == bwd) return STEP_DN;
    else                 return STEP_ERR;
  endfunction

endpackage

// File: rtl/safe_enc_debounce.sv
// -----------------------------------------------------------------------------
// safe_enc_debounce
// Two-flop synchronizer followed by a level filter for one encoder pin. A new
// level is accepted only after DEB_CYCLES consecutive synchronized samples that
// all differ from the currently accepted level; any matching sample restarts
// the count.
// Ports:
//   clk    in  clock
//   rst    in  asynchronous active-high reset
//   pin    in  raw asynchronous pin
//   level  out accepted (debounced) level, resets to 0
// -----------------------------------------------------------------------------
module safe_enc_debounce
  import safe_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 != level) begin
        // This sample is the DEB_CYCLES-th consecutive differing one.
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/safe_dial_frontend.sv
// -----------------------------------------------------------------------------
// safe_dial_frontend
// Rotary dial front end for the safe: debounces the quadrature pair, decodes
// Gray-code detent steps, tracks the dial position modulo DIAL_MAX and compares
// it with the combination digit chosen by sel.
// Optional build macro SAFE_DIAL_PROG_EN adds runtime-writable combination
// registers; without it the combination digits are the COMBO0..2 parameters.
// Ports:
//   clk        in  clock
//   rst        in  asynchronous active-high reset
//   enc_a      in  quadrature A pin (asynchronous)
//   enc_b      in  quadrature B pin (asynchronous)
//   clr_count  in  synchronous clear of position and direction history
//   sel[1:0]   in  combination digit select (3 = reserved, eq forced low)
//   cnten      out one-cycle pulse per accepted step
//   up         out direction of last step (1 = up)
//   dirch      out pulse with cnten when the direction reverses
//   pos        out dial position 0..DIAL_MAX-1
//   eq         out pos matches selected combination digit
//   enc_err    out one-cycle pulse on an illegal two-bit AB jump
//   prog_en, prog_we, prog_idx[1:0], prog_data  (SAFE_DIAL_PROG_EN only)
//              combination register write port
// -----------------------------------------------------------------------------
module safe_dial_frontend
  import safe_pkg::*;
#(
  parameter int DIAL_MAX   = DIAL_MAX_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int COMBO0     = COMBO0_DEF,
  parameter int COMBO1     = COMBO1_DEF,
  parameter int COMBO2     = COMBO2_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr_count,
  input  logic [1:0]       sel,
  output logic             cnten,
  output logic             up,
  output logic             dirch,
  output logic [CNT_W-1:0] pos,
  output logic             eq,
  output logic             enc_err
`ifdef SAFE_DIAL_PROG_EN
  ,
  input  logic             prog_en,
  input  logic             prog_we,
  input  logic [1:0]       prog_idx,
  input  logic [CNT_W-1:0] prog_data
`endif
);

  logic             deb_a;
  logic             deb_b;
  logic [1:0]       ab_cur;
  logic [1:0]       ab_acc;
  step_t            step;
  logic             step_v;
  logic             step_up;
  logic             hist;
  logic [CNT_W-1:0] pos_inc;
  logic [CNT_W-1:0] pos_dec;
  logic [CNT_W-1:0] combo0;
  logic [CNT_W-1:0] combo1;
  logic [CNT_W-1:0] combo2;
  logic [CNT_W-1:0] combo_sel;
  logic             sel_ok;

  safe_enc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .pin   (enc_a),
    .level (deb_a)
  );

  safe_enc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .pin   (enc_b),
    .level (deb_b)
  );

  always_comb begin
    step    = gray_step(ab_acc, ab_cur);
    step_v  = (step == STEP_UP) || (step == STEP_DN);
    step_up = (step == STEP_UP);
    pos_inc = (pos == CNT_W'(DIAL_MAX - 1)) ? '0 : pos + CNT_W'(1);
    pos_dec = (pos == '0) ? CNT_W'(DIAL_MAX - 1) : pos - CNT_W'(1);
  end

  // ab_cur is a registered copy of the debounced pair; ab_acc is the pair the
  // last decision was made on. The extra stage sets the pin-to-cnten latency
  // to 3 + DEB_CYCLES. pos moves one edge after cnten so the turnaround
  // position is still visible while dirch is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ab_cur  <= 2'b00;
      ab_acc  <= 2'b00;
      cnten   <= 1'b0;
      up      <= 1'b0;
      dirch   <= 1'b0;
      hist    <= 1'b0;
      pos     <= '0;
      enc_err <= 1'b0;
    end else begin
      ab_cur  <= {deb_a, deb_b};
      ab_acc  <= ab_cur;
      enc_err <= (step == STEP_ERR);
      if (clr_count) begin
        cnten <= 1'b0;
        dirch <= 1'b0;
        up    <= 1'b0;
        hist  <= 1'b0;
        pos   <= '0;
      end else begin
        cnten <= step_v;
        dirch <= step_v && hist && (step_up != up);
        if (step_v) begin
          up   <= step_up;
          hist <= 1'b1;
        end
        if (cnten) pos <= up ? pos_inc : pos_dec;
      end
    end
  end

`ifdef SAFE_DIAL_PROG_EN
  logic prog_ok;
  assign prog_ok = prog_en && prog_we && (prog_idx != SEL_RSV) &&
                   (int'(prog_data) < DIAL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      combo0 <= CNT_W'(COMBO0);
      combo1 <= CNT_W'(COMBO1);
      combo2 <= CNT_W'(COMBO2);
    end else if (prog_ok) begin
      case (prog_idx)
        SEL_D0:  combo0 <= prog_data;
        SEL_D1:  combo1 <= prog_data;
        default: combo2 <= prog_data;
      endcase
    end
  end
`else
  assign combo0 = CNT_W'(COMBO0);
  assign combo1 = CNT_W'(COMBO1);
  assign combo2 = CNT_W'(COMBO2);
`endif

  always_comb begin
    combo_sel = '0;
    sel_ok    = 1'b1;
    case (sel)
      SEL_D0:  combo_sel = combo0;
      SEL_D1:  combo_sel = combo1;
      SEL_D2:  combo_sel = combo2;
      default: sel_ok    = 1'b0;
    endcase
  end

  assign eq = sel_ok && (pos == combo_sel);

endmodule

// File: tb/tb_safe_dial_frontend.sv
module tb_safe_dial_frontend;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             enc_a;
  logic             enc_b;
  logic             clr_count;
  logic [1:0]       sel;
  logic             cnten;
  logic             up;
  logic             dirch;
  logic [CNT_W-1:0] pos;
  logic             eq;
  logic             enc_err;
`ifdef SAFE_DIAL_PROG_EN
  logic             prog_en;
  logic             prog_we;
  logic [1:0]       prog_idx;
  logic [CNT_W-1:0] prog_data;
`endif

  always #5 clk = ~clk;

  safe_dial_frontend dut (
    .clk       (clk),
    .rst       (rst),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .clr_count (clr_count),
    .sel       (sel),
    .cnten     (cnten),
    .up        (up),
    .dirch     (dirch),
    .pos       (pos),
    .eq        (eq),
    .enc_err   (enc_err)
`ifdef SAFE_DIAL_PROG_EN
    ,
    .prog_en   (prog_en),
    .prog_we   (prog_we),
    .prog_idx  (prog_idx),
    .prog_data (prog_data)
`endif
  );

  // Pulse counters, sampled on the inactive edge.
  int n_cnten = 0;
  int n_dirch = 0;
  int n_err   = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (cnten)   n_cnten <= n_cnten + 1;
      if (dirch)   n_dirch <= n_dirch + 1;
      if (enc_err) n_err   <= n_err + 1;
    end
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [1:0] ab;
    logic [1:0] sel;
    int         d_cnten;
    int         d_dirch;
    int         d_err;
    logic       up;
    int         pos;
    logic       eq;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  task automatic run_vec(input vec_t v);
    int c0, d0, e0;
    c0 = n_cnten; d0 = n_dirch; e0 = n_err;
    enc_a = v.ab[1];
    enc_b = v.ab[0];
    sel   = v.sel;
    repeat (12) @(posedge clk);
    #1;
    chk({v.name, ".cnten"}, n_cnten - c0, v.d_cnten);
    chk({v.name, ".dirch"}, n_dirch - d0, v.d_dirch);
    chk({v.name, ".err"},   n_err - e0,   v.d_err);
    chk({v.name, ".up"},    int'(up),     int'(v.up));
    chk({v.name, ".pos"},   int'(pos),    v.pos);
    chk({v.name, ".eq"},    int'(eq),     int'(v.eq));
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) run_vec(vt[i]);
  endtask

  task automatic step_ab(input logic [1:0] ab);
    enc_a = ab[1];
    enc_b = ab[0];
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
  endtask

  logic [1:0] up_seq [4];
  int c0, d0, e0, hit;

  initial begin
    vt[0]  = '{"up2",        2'b11, 2'd0, 1, 0, 0, 1'b1,  2, 1'b0};
    vt[1]  = '{"up3",        2'b10, 2'd0, 1, 0, 0, 1'b1,  3, 1'b0};
    vt[2]  = '{"up4",        2'b00, 2'd0, 1, 0, 0, 1'b1,  4, 1'b0};
    vt[3]  = '{"jump00_11",  2'b11, 2'd0, 0, 0, 1, 1'b1,  4, 1'b0};
    vt[4]  = '{"jump11_00",  2'b00, 2'd0, 0, 0, 1, 1'b1,  4, 1'b0};
    vt[5]  = '{"rev_up",     2'b00, 2'd0, 1, 1, 0, 1'b1,  4, 1'b0};
    vt[6]  = '{"dn_to0",     2'b00, 2'd0, 1, 1, 0, 1'b0,  0, 1'b0};
    vt[7]  = '{"dn_wrap",    2'b10, 2'd0, 1, 0, 0, 1'b0, 39, 1'b0};
    vt[8]  = '{"dn10",       2'b01, 2'd2, 1, 0, 0, 1'b0, 10, 1'b0};
    vt[9]  = '{"dn9",        2'b00, 2'd2, 1, 0, 0, 1'b0,  9, 1'b0};
    vt[10] = '{"dn8",        2'b10, 2'd2, 1, 0, 0, 1'b0,  8, 1'b0};
    vt[11] = '{"dn7_eq",     2'b11, 2'd2, 1, 0, 0, 1'b0,  7, 1'b1};
    vt[12] = '{"sel3",       2'b11, 2'd3, 0, 0, 0, 1'b0,  7, 1'b0};
    vt[13] = '{"sel1",       2'b11, 2'd1, 0, 0, 0, 1'b0,  7, 1'b0};
    vt[14] = '{"first_clr",  2'b11, 2'd0, 1, 0, 0, 1'b0, 39, 1'b0};
    vt[15] = '{"dn38",       2'b01, 2'd0, 1, 0, 0, 1'b0, 38, 1'b0};
    vt[16] = '{"rev_clr",    2'b11, 2'd0, 1, 1, 0, 1'b1, 39, 1'b0};

    up_seq[0] = 2'b01; up_seq[1] = 2'b11; up_seq[2] = 2'b10; up_seq[3] = 2'b00;

    rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; clr_count = 1'b0; sel = 2'd0;
`ifdef SAFE_DIAL_PROG_EN
    prog_en = 1'b0; prog_we = 1'b0; prog_idx = 2'd0; prog_data = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst.cnten",   int'(cnten),   0);
    chk("rst.up",      int'(up),      0);
    chk("rst.dirch",   int'(dirch),   0);
    chk("rst.pos",     int'(pos),     0);
    chk("rst.enc_err", int'(enc_err), 0);
    chk("rst.eq",      int'(eq),      0);

    // First step 00->01, latency from the sampling edge to the cnten cycle.
    c0 = n_cnten; d0 = n_dirch; hit = -1;
    enc_b = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (cnten && hit < 0) hit = k;
    end
    chk("lat.edge",  hit, 7);
    chk("lat.count", n_cnten - c0, 1);
    chk("lat.dirch", n_dirch - d0, 0);
    chk("lat.up",    int'(up),  1);
    chk("lat.pos",   int'(pos), 1);

    run_rows(0, 4);

    // Glitch: A high for 3 sampling edges is rejected.
    c0 = n_cnten;
    enc_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    enc_a = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch3.cnten", n_cnten - c0, 0);
    chk("glitch3.pos",   int'(pos), 4);

    // A held high (00->10): one down step, reversal from up.
    c0 = n_cnten; d0 = n_dirch;
    enc_a = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch4.cnten", n_cnten - c0, 1);
    chk("glitch4.dirch", n_dirch - d0, 1);
    chk("glitch4.up",    int'(up),  0);
    chk("glitch4.pos",   int'(pos), 3);

    run_rows(5, 5);

    // Clear, then 41 up steps wrap to 1.
    pulse_clr();
    chk("clr.pos", int'(pos), 0);
    chk("clr.up",  int'(up),  0);
    c0 = n_cnten; d0 = n_dirch;
    for (int i = 0; i < 41; i++) step_ab(up_seq[i % 4]);
    chk("wrap41.cnten", n_cnten - c0, 41);
    chk("wrap41.dirch", n_dirch - d0, 0);
    chk("wrap41.pos",   int'(pos), 1);

    run_rows(6, 7);

    // Up to 12 from AB=10, then reverse and check the turnaround cycle.
    pulse_clr();
    for (int i = 0; i < 12; i++) step_ab(up_seq[(i + 3) % 4]);
    chk("at12.pos", int'(pos), 12);
    chk("at12.eq",  int'(eq),  1);
    enc_a = 1'b1; enc_b = 1'b1;
    hit = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (cnten) begin
        hit = 1;
        break;
      end
    end
    chk("dirchg.seen", hit, 1);
    chk("dirchg.dirch", int'(dirch), 1);
    chk("dirchg.up",    int'(up),    0);
    chk("dirchg.pos",   int'(pos),   12);
    chk("dirchg.eq",    int'(eq),    1);
    @(posedge clk);
    #1;
    chk("dirchg.pos_next", int'(pos), 11);
    chk("dirchg.eq_next",  int'(eq),  0);
    repeat (4) @(posedge clk);
    #1;

    run_rows(8, 13);

    // clr_count in the decode cycle of an up step 11->10 discards it.
    sel = 2'd0;
    c0 = n_cnten;
    enc_a = 1'b1; enc_b = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    clr_count = 1'b1;
    @(posedge clk);
    #1;
    clr_count = 1'b0;
    chk("clrstep.cnten_now", int'(cnten), 0);
    chk("clrstep.pos_now",   int'(pos),   0);
    repeat (6) @(posedge clk);
    #1;
    chk("clrstep.cnten", n_cnten - c0, 0);
    chk("clrstep.pos",   int'(pos), 0);

    run_rows(14, 16);

    // Asynchronous reset in the middle of debouncing: no step after release.
    c0 = n_cnten; e0 = n_err;
    enc_a = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #2;
    chk("arst.pos_imm", int'(pos), 0);
    enc_a = 1'b0; enc_b = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    chk("arst.cnten", n_cnten - c0, 0);
    chk("arst.err",   n_err - e0,   0);
    chk("arst.pos",   int'(pos),    0);

`ifdef SAFE_DIAL_PROG_EN
    sel = 2'd1;
    prog_en = 1'b0; prog_we = 1'b1; prog_idx = 2'd1; prog_data = '0;
    @(posedge clk);
    #1;
    chk("prog.disabled_eq", int'(eq), 0);
    prog_en = 1'b1; prog_data = CNT_W'(25);
    @(posedge clk);
    #1;
    prog_data = CNT_W'(45);
    @(posedge clk);
    #1;
    prog_we = 1'b0; prog_en = 1'b0;
    for (int i = 0; i < 25; i++) step_ab(up_seq[i % 4]);
    chk("prog.pos", int'(pos), 25);
    chk("prog.eq",  int'(eq),  1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
